// File: rtl/addr_gen_ctrl.sv
// Effective-address / immediate generator for the sLC-3 datapath (IDLE -> CALC -> HOLD).
// Optional perf counters (cnt_done, cnt_illegal) are built when AGC_PERF_CNT_EN is defined.
module addr_gen_ctrl #(
    parameter int unsigned PC_INC = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] ir_in,
    input  logic [15:0] pc_in,
    input  logic [15:0] base_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] ea_out,
    output logic [15:0] imm_out,
    output logic [1:0]  src_sel,
    output logic        illegal
`ifdef AGC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_done,
    output logic [CNT_W-1:0] cnt_illegal
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StHold = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OpBr   = 4'h0,
        OpAdd  = 4'h1,
        OpLd   = 4'h2,
        OpSt   = 4'h3,
        OpJsr  = 4'h4,
        OpAnd  = 4'h5,
        OpLdr  = 4'h6,
        OpStr  = 4'h7,
        OpRti  = 4'h8,
        OpNot  = 4'h9,
        OpLdi  = 4'hA,
        OpSti  = 4'hB,
        OpJmp  = 4'hC,
        OpRsv  = 4'hD,
        OpLea  = 4'hE,
        OpTrap = 4'hF
    } opcode_e;

    localparam logic [1:0] SrcNone = 2'd0;
    localparam logic [1:0] SrcPc   = 2'd1;
    localparam logic [1:0] SrcBase = 2'd2;
    localparam logic [1:0] SrcTrap = 2'd3;

    state_e state_q, state_d;

    logic [15:0] ir_q, pc_q, base_q;
    logic [15:0] ea_q, imm_q;
    logic [1:0]  src_q;
    logic        ill_q;

    logic [15:0] imm_d, ea_d, pc_eff, addend;
    logic [1:0]  src_d;
    logic        ill_d;
    logic        use_pc, use_base;
    logic        accept, consume;
    opcode_e     op;

    assign accept  = req_valid && req_ready;
    assign consume = (state_q == StHold) && res_ready;
    assign op      = opcode_e'(ir_q[15:12]);

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StCalc;
            StCalc: state_d = StHold;
            StHold: if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Gate with Reset_n so no request is advertised while the block is held in reset.
    assign req_ready = (state_q == StIdle) && Reset_n;
    assign res_valid = (state_q == StHold);

    // ------------------------------------------------------------------
    // Request capture: operands frozen at accept, later input changes ignored
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ir_q   <= '0;
            pc_q   <= '0;
            base_q <= '0;
        end else if (accept) begin
            ir_q   <= ir_in;
            pc_q   <= pc_in;
            base_q <= base_in;
        end
    end

    // ------------------------------------------------------------------
    // Field select, extension and address add
    // ------------------------------------------------------------------
    assign pc_eff = (PC_INC != 0) ? pc_q : (pc_q + 16'd1);

    always_comb begin
        imm_d    = '0;
        src_d    = SrcNone;
        ill_d    = 1'b0;
        use_pc   = 1'b0;
        use_base = 1'b0;
        unique case (op)
            OpAdd, OpAnd: begin
                if (ir_q[5]) imm_d = {{11{ir_q[4]}}, ir_q[4:0]};
            end
            OpBr, OpLd, OpSt, OpLdi, OpSti, OpLea: begin
                imm_d  = {{7{ir_q[8]}}, ir_q[8:0]};
                src_d  = SrcPc;
                use_pc = 1'b1;
            end
            OpJsr: begin
                if (ir_q[11]) begin
                    imm_d  = {{5{ir_q[10]}}, ir_q[10:0]};
                    src_d  = SrcPc;
                    use_pc = 1'b1;
                end else begin
                    src_d    = SrcBase;
                    use_base = 1'b1;
                end
            end
            OpJmp: begin
                src_d    = SrcBase;
                use_base = 1'b1;
            end
            OpLdr, OpStr: begin
                imm_d    = {{10{ir_q[5]}}, ir_q[5:0]};
                src_d    = SrcBase;
                use_base = 1'b1;
            end
            OpTrap: begin
                imm_d = {8'h00, ir_q[7:0]};
                src_d = SrcTrap;
            end
            OpRti, OpRsv: begin
                ill_d = 1'b1;
            end
            OpNot: begin
                imm_d = '0;
            end
            default: begin
                imm_d = '0;
            end
        endcase
    end

    always_comb begin
        addend = '0;
        if (use_pc) begin
            addend = pc_eff;
        end else if (use_base) begin
            addend = base_q;
        end
    end

    // Modulo-2^16 sum; carry out is deliberately dropped.
    assign ea_d = imm_d + addend;

    // ------------------------------------------------------------------
    // Result registers: loaded only in CALC so they stay stable through HOLD
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ea_q  <= '0;
            imm_q <= '0;
            src_q <= SrcNone;
            ill_q <= 1'b0;
        end else if (state_q == StCalc) begin
            ea_q  <= ea_d;
            imm_q <= imm_d;
            src_q <= src_d;
            ill_q <= ill_d;
        end
    end

    assign ea_out  = ea_q;
    assign imm_out = imm_q;
    assign src_sel = src_q;
    assign illegal = ill_q;

`ifdef AGC_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters, bumped on each consumed result
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_done_q, cnt_ill_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_done_q <= '0;
            cnt_ill_q  <= '0;
        end else if (consume) begin
            if (cnt_done_q != '1) cnt_done_q <= cnt_done_q + 1'b1;
            if (ill_q && (cnt_ill_q != '1)) cnt_ill_q <= cnt_ill_q + 1'b1;
        end
    end

    assign cnt_done    = cnt_done_q;
    assign cnt_illegal = cnt_ill_q;
`else
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule

// File: tb/tb_addr_gen_ctrl.sv
// Directed self-checking bench for addr_gen_ctrl; a second instance runs with PC_INC=0.
// Result latency convention: accept at edge N, res_valid seen after edge N+1 (sampled by consumer at N+2).
module tb_addr_gen_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [15:0] ir_in = '0;
    logic [15:0] pc_in = '0;
    logic [15:0] base_in = '0;

    logic        req_ready, res_valid, illegal;
    logic [15:0] ea_out, imm_out;
    logic [1:0]  src_sel;

    logic        req_ready0, res_valid0, illegal0;
    logic [15:0] ea_out0, imm_out0;
    logic [1:0]  src_sel0;

    int checks = 0;
    int failures = 0;

`ifdef AGC_PERF_CNT_EN
    logic [1:0] cnt_done, cnt_illegal, cnt_done0, cnt_illegal0;
`endif

    always #5 Clk = ~Clk;

    addr_gen_ctrl #(.PC_INC(1), .CNT_W(2)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .ir_in(ir_in), .pc_in(pc_in), .base_in(base_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .ea_out(ea_out), .imm_out(imm_out), .src_sel(src_sel), .illegal(illegal)
`ifdef AGC_PERF_CNT_EN
        , .cnt_done(cnt_done), .cnt_illegal(cnt_illegal)
`endif
    );

    addr_gen_ctrl #(.PC_INC(0), .CNT_W(2)) u_dut0 (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready0),
        .ir_in(ir_in), .pc_in(pc_in), .base_in(base_in),
        .res_valid(res_valid0), .res_ready(res_ready),
        .ea_out(ea_out0), .imm_out(imm_out0), .src_sel(src_sel0), .illegal(illegal0)
`ifdef AGC_PERF_CNT_EN
        , .cnt_done(cnt_done0), .cnt_illegal(cnt_illegal0)
`endif
    );

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic [15:0] pc;
        logic [15:0] base;
        logic [15:0] ea;
        logic [15:0] imm;
        logic [1:0]  sel;
        logic        ill;
    } vec_t;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue one request, scramble inputs during CALC, wait (bounded) for res_valid.
    task automatic run_txn(input logic [15:0] ir, input logic [15:0] pc, input logic [15:0] base);
        int lat;
        ir_in = ir; pc_in = pc; base_in = base; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL txn_req_ready ir=%h got=%b want=1", ir, req_ready);
        end
        step();
        req_valid = 1'b0;
        ir_in = ~ir; pc_in = pc ^ 16'h5A5A; base_in = ~base;
        checks++;
        if (res_valid !== 1'b0) begin
            failures++;
            $display("FAIL txn_calc_valid ir=%h got=%b want=0", ir, res_valid);
        end
        lat = 0;
        while (res_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        checks++;
        if (lat != 1) begin
            failures++;
            $display("FAIL txn_latency ir=%h got=%0d want=1", ir, lat);
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL consume_idle got valid=%b ready=%b want valid=0 ready=1",
                     res_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        #12;
        checks++;
        if (res_valid !== 1'b0 || ea_out !== 16'h0 || imm_out !== 16'h0 ||
            src_sel !== 2'd0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b ea=%h imm=%h sel=%0d ill=%b want all 0",
                     res_valid, ea_out, imm_out, src_sel, illegal);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready got=%b want=1", req_ready);
        end
`ifdef AGC_PERF_CNT_EN
        checks++;
        if (cnt_done !== 2'd0 || cnt_illegal !== 2'd0) begin
            failures++;
            $display("FAIL reset_counters got done=%0d ill=%0d want 0 0", cnt_done, cnt_illegal);
        end
`endif
    endtask

    task automatic test_decode();
        vec_t v[$];
        v.push_back('{"ldr",   16'h6A7F, 16'h3001, 16'h3000, 16'h2FFF, 16'hFFFF, 2'd2, 1'b0});
        v.push_back('{"br",    16'h0FFF, 16'h3001, 16'h3000, 16'h3000, 16'hFFFF, 2'd1, 1'b0});
        v.push_back('{"jsr",   16'h4C00, 16'h3001, 16'h3000, 16'h2C01, 16'hFC00, 2'd1, 1'b0});
        v.push_back('{"trap",  16'hF025, 16'h3001, 16'h3000, 16'h0025, 16'h0025, 2'd3, 1'b0});
        v.push_back('{"ldwrap",16'h20FF, 16'hFFF0, 16'h3000, 16'h00EF, 16'h00FF, 2'd1, 1'b0});
        v.push_back('{"rsv",   16'hD000, 16'h3001, 16'h3000, 16'h0000, 16'h0000, 2'd0, 1'b1});
        v.push_back('{"rti",   16'h8000, 16'h3001, 16'h3000, 16'h0000, 16'h0000, 2'd0, 1'b1});
        v.push_back('{"addi",  16'h1021, 16'h3001, 16'h3000, 16'h0001, 16'h0001, 2'd0, 1'b0});
        v.push_back('{"addr",  16'h1001, 16'h3001, 16'h3000, 16'h0000, 16'h0000, 2'd0, 1'b0});
        v.push_back('{"andi",  16'h5030, 16'h3001, 16'h3000, 16'hFFF0, 16'hFFF0, 2'd0, 1'b0});
        v.push_back('{"jmp",   16'hC1C0, 16'h3001, 16'h1234, 16'h1234, 16'h0000, 2'd2, 1'b0});
        v.push_back('{"jsrr",  16'h4080, 16'h3001, 16'h1234, 16'h1234, 16'h0000, 2'd2, 1'b0});
        v.push_back('{"str",   16'h7041, 16'h3001, 16'h3000, 16'h3001, 16'h0001, 2'd2, 1'b0});
        v.push_back('{"lea",   16'hE100, 16'h3001, 16'h3000, 16'h2F01, 16'hFF00, 2'd1, 1'b0});
        v.push_back('{"st",    16'h3E01, 16'h4000, 16'h3000, 16'h4001, 16'h0001, 2'd1, 1'b0});
        foreach (v[i]) begin
            run_txn(v[i].ir, v[i].pc, v[i].base);
            checks++;
            if (ea_out !== v[i].ea || imm_out !== v[i].imm ||
                src_sel !== v[i].sel || illegal !== v[i].ill) begin
                failures++;
                $display("FAIL decode_%s got ea=%h imm=%h sel=%0d ill=%b want ea=%h imm=%h sel=%0d ill=%b",
                         v[i].name, ea_out, imm_out, src_sel, illegal,
                         v[i].ea, v[i].imm, v[i].sel, v[i].ill);
            end
            consume();
        end
    endtask

    task automatic test_pc_inc();
        run_txn(16'h0FFF, 16'h3001, 16'h0000);
        checks++;
        if (ea_out0 !== 16'h3001 || src_sel0 !== 2'd1) begin
            failures++;
            $display("FAIL pcinc0_br got ea=%h sel=%0d want ea=3001 sel=1", ea_out0, src_sel0);
        end
        consume();
        run_txn(16'h20FF, 16'hFFF0, 16'h0000);
        checks++;
        if (ea_out0 !== 16'h00F0) begin
            failures++;
            $display("FAIL pcinc0_ldwrap got ea=%h want ea=00F0", ea_out0);
        end
        consume();
    endtask

    task automatic test_backpressure();
        run_txn(16'h6A7F, 16'h3001, 16'h3000);
        // A competing request must not be taken while HOLD is stalled.
        ir_in = 16'hF025; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (res_valid !== 1'b1 || req_ready !== 1'b0 || ea_out !== 16'h2FFF ||
                imm_out !== 16'hFFFF || src_sel !== 2'd2) begin
                failures++;
                $display("FAIL backpressure_c%0d got v=%b rdy=%b ea=%h imm=%h sel=%0d want v=1 rdy=0 ea=2FFF imm=FFFF sel=2",
                         c, res_valid, req_ready, ea_out, imm_out, src_sel);
            end
        end
        req_valid = 1'b0;
        consume();
        step();
        checks++;
        if (res_valid !== 1'b0 || ea_out !== 16'h2FFF) begin
            failures++;
            $display("FAIL backpressure_no_accept got v=%b ea=%h want v=0 ea=2FFF", res_valid, ea_out);
        end
    endtask

    task automatic test_reset_in_hold();
        run_txn(16'hF025, 16'h3001, 16'h3000);
        Reset_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || ea_out !== 16'h0 || src_sel !== 2'd0) begin
            failures++;
            $display("FAIL reset_hold got v=%b ea=%h sel=%0d want v=0 ea=0000 sel=0",
                     res_valid, ea_out, src_sel);
        end
        #3;
        Reset_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold_recover got rdy=%b v=%b want rdy=1 v=0", req_ready, res_valid);
        end
    endtask

    task automatic test_back_to_back();
        int hits = 0;
        ir_in = 16'h1021; pc_in = 16'h0; base_in = 16'h0;
        req_valid = 1'b1; res_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step();
            if (res_valid === 1'b1) begin
                hits++;
                checks++;
                if (ea_out !== 16'h0001) begin
                    failures++;
                    $display("FAIL b2b_ea got=%h want=0001", ea_out);
                end
            end
        end
        req_valid = 1'b0; res_ready = 1'b0;
        checks++;
        if (hits != 3) begin
            failures++;
            $display("FAIL b2b_throughput got=%0d want=3", hits);
        end
    endtask

`ifdef AGC_PERF_CNT_EN
    task automatic test_perf();
        test_reset();
        run_txn(16'hD000, 16'h0, 16'h0);
        consume();
        for (int k = 0; k < 3; k++) begin
            run_txn(16'h1021, 16'h0, 16'h0);
            consume();
        end
        checks++;
        if (cnt_done !== 2'd3 || cnt_illegal !== 2'd1) begin
            failures++;
            $display("FAIL perf_saturate got done=%0d ill=%0d want 3 1", cnt_done, cnt_illegal);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_decode();
        test_pc_inc();
        test_backpressure();
        test_reset_in_hold();
        test_back_to_back();
`ifdef AGC_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
